// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: op codes, FSM states and compare flags.
package alu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    EQ  = 3'd5,
    MUL = 3'd6,
    DIV = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic greater;
    logic equal;
    logic less;
  } cmp_flags_t;

  // Only MUL produces a double-width result; everything else is zero-extended.
  function automatic logic is_wide_op(input op_t op);
    return op == MUL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    w_found    = 1'b0;
    w_cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (en && !w_found && req[w_cand]) begin
        w_found            = 1'b1;
        gnt_onehot[w_cand] = 1'b1;
        gnt_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin grant, then
// IDLE -> ISSUE -> WAIT -> RESP; divide-by-zero is trapped without touching the ALU.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     rsp_carry,
  output logic [FLAG_W-1:0]        rsp_flags,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OP_W-1:0]          alu_select,
  output logic                     alu_enable,
  input  logic [2*WIDTH-1:0]       alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_greater,
  input  logic                     alu_equal,
  input  logic                     alu_less
);

  localparam int unsigned     RES_W   = 2 * WIDTH;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] w_a_arr  [NUM_REQ];
  logic [WIDTH-1:0] w_b_arr  [NUM_REQ];
  op_t              w_op_arr [NUM_REQ];

  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_arb_en;
  logic               w_grant;
  logic               w_div0;
  logic               w_rsp_fire;
  logic               w_alu_active;
  logic [RES_W-1:0]   w_alu_res;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  op_t                r_op;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_ptr;
  logic [RES_W-1:0]   r_rsp_result;
  logic               r_rsp_carry;
  cmp_flags_t         r_rsp_flags;
  logic               r_rsp_err;

  // Unpack the flat requester buses into per-requester views.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign w_a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
    assign w_op_arr[gi] = op_t'(req_op[gi*OP_W +: OP_W]);
  end

  // Arbitration only in IDLE and never while reset is asserted.
  assign w_arb_en = arst && (r_state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .ptr        (r_ptr),
    .en         (w_arb_en),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  assign w_div0     = (w_op_arr[w_gnt_idx] == DIV) && (w_b_arr[w_gnt_idx] == '0);
  assign w_rsp_fire = (r_state == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt_onehot) begin
          req_ready   = w_gnt_onehot;
          w_grant     = 1'b1;
          w_state_nxt = w_div0 ? RESP : ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Non-MUL results only carry WIDTH meaningful bits.
  assign w_alu_res = is_wide_op(r_op) ? alu_out : RES_W'(alu_out[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= ADD;
      r_id         <= '0;
      r_ptr        <= PTR_RST;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_a         <= w_a_arr[w_gnt_idx];
        r_b         <= w_b_arr[w_gnt_idx];
        r_op        <= w_op_arr[w_gnt_idx];
        r_id        <= w_gnt_idx;
        r_rsp_err   <= w_div0;
        r_rsp_carry <= 1'b0;
        if (w_div0) begin
          r_rsp_result <= '1;
          r_rsp_flags  <= '0;
        end
      end
      if (r_state == WAIT) begin
        r_rsp_result        <= w_alu_res;
        r_rsp_carry         <= alu_carry && (r_op == ADD);
        r_rsp_flags.greater <= alu_greater;
        r_rsp_flags.equal   <= alu_equal;
        r_rsp_flags.less    <= alu_less;
      end
      if (w_rsp_fire) begin
        r_ptr <= r_id;
      end
    end
  end

  // ALU inputs are held for ISSUE and WAIT so the compare flags stay valid at capture.
  assign w_alu_active = (r_state == ISSUE) || (r_state == WAIT);
  assign alu_a        = w_alu_active ? r_a : '0;
  assign alu_b        = w_alu_active ? r_b : '0;
  assign alu_select   = w_alu_active ? OP_W'(r_op) : '0;
  assign alu_enable   = (r_state == ISSUE);

  assign rsp_valid  = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;

endmodule
